// File: rtl/uart_pkg.sv
// Shared UART definitions: main-state encoding (common to TX and RX) and frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_IDX_W     = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    START   = 3'b001,
    DATA    = 3'b010,
    STOP    = 3'b011,
    CLEANUP = 3'b100,
    PARITY  = 3'b101
  } uart_state_t;

endpackage

// File: rtl/uart_tx_state_handler.sv
// Combinational next-state logic for the UART transmitter.
// The PARITY state is only reachable when UART_TX_PARITY_EN is defined.
module uart_tx_state_handler
  import uart_pkg::*;
(
  input  uart_state_t                  state,
  input  logic                         tx_dv,
  input  logic [15:0]                  clk_count,
  input  logic [UART_IDX_W-1:0]        bit_index,
  input  logic [15:0]                  clks_per_bit,
  output uart_state_t                  next_state
);

  logic bit_end;
  logic last_bit;

  assign bit_end  = (clk_count == clks_per_bit - 16'd1);
  assign last_bit = (bit_index == UART_IDX_W'(UART_DATA_BITS - 1));

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = tx_dv ? START : IDLE;
      START:   next_state = bit_end ? DATA : START;
      DATA: begin
        if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end else begin
          next_state = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY:  next_state = bit_end ? STOP : PARITY;
`endif
      STOP:    next_state = bit_end ? CLEANUP : STOP;
      CLEANUP: next_state = IDLE;
      // Unused codes (including 101 without parity) recover to IDLE.
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; define UART_TX_PARITY_EN to insert an even-parity bit.
// All outputs are registered from the next-state decode so the TX pin never glitches.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam logic [15:0] CPB = 16'(CLKS_PER_BIT);

  uart_state_t                 state;
  uart_state_t                 next_state;
  logic [15:0]                 clk_count;
  logic [15:0]                 clk_count_next;
  logic [UART_IDX_W-1:0]       bit_index;
  logic [UART_IDX_W-1:0]       bit_index_next;
  logic [UART_DATA_BITS-1:0]   tx_byte;
  logic [UART_DATA_BITS-1:0]   tx_byte_next;
  logic                        serial_next;
  logic                        active_next;
  logic                        done_next;
  logic                        bit_end;

  assign bit_end = (clk_count == CPB - 16'd1);

  uart_tx_state_handler u_state_handler (
    .state        (state),
    .tx_dv        (i_Tx_DV),
    .clk_count    (clk_count),
    .bit_index    (bit_index),
    .clks_per_bit (CPB),
    .next_state   (next_state)
  );

  always_comb begin
    clk_count_next = clk_count + 16'd1;
    bit_index_next = bit_index;
    tx_byte_next   = tx_byte;
    case (state)
      IDLE: begin
        clk_count_next = 16'd0;
        bit_index_next = '0;
        if (i_Tx_DV) tx_byte_next = i_Tx_Byte;
      end
      DATA: begin
        if (bit_end) begin
          clk_count_next = 16'd0;
          if (next_state == DATA) bit_index_next = bit_index + 1'b1;
        end
      end
      CLEANUP: clk_count_next = 16'd0;
      default: ;
    endcase
    if (next_state != state) clk_count_next = 16'd0;

    // Output values for the cycle that next_state will occupy.
    serial_next = 1'b1;
    active_next = 1'b0;
    done_next   = 1'b0;
    case (next_state)
      START: begin
        serial_next = 1'b0;
        active_next = 1'b1;
      end
      DATA: begin
        serial_next = tx_byte_next[bit_index_next];
        active_next = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_next = ^tx_byte_next;
        active_next = 1'b1;
      end
`endif
      STOP:    active_next = 1'b1;
      CLEANUP: done_next   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      clk_count   <= 16'd0;
      bit_index   <= '0;
      tx_byte     <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= next_state;
      clk_count   <= clk_count_next;
      bit_index   <= bit_index_next;
      tx_byte     <= tx_byte_next;
      o_Tx_Serial <= serial_next;
      o_Tx_Active <= active_next;
      o_Tx_Done   <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4; honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_serial;
  logic       tx_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [10:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit 0 is sent first: start, d0..d7, stop
    logic       par;
  } vec_t;

  vec_t vecs[7];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Tx_DV     (tx_dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Active (tx_active),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Done   (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [10:0] mk_line(input logic [9:0] base, input logic par);
`ifdef UART_TX_PARITY_EN
    return {1'b1, par, base[8:0]};
`else
    return {1'b0, base};
`endif
  endfunction

  task automatic pulse(input logic [7:0] b);
    tx_byte = b;
    tx_dv   = 1'b1;
    @(negedge clk);
    tx_dv   = 1'b0;
  endtask

  // Waits for a start bit, samples mid-bit, pops the expected line and checks Done timing.
  task automatic frame_mon(output int fall_cyc);
    logic [10:0] exp;
    bit got;
    got = 0;
    exp = '1;
    fall_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_serial === 1'b0) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("frame_start_timeout", 0, 1);
      return;
    end
    fall_cyc = cyc;
    chk("active_at_start", tx_active, 1);
    if (sb.size() == 0) chk("unexpected_frame", 1, 0);
    else exp = sb.pop_front();
    repeat (CPB / 2) @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("line_bit%0d", k), tx_serial, exp[k]);
      if (k != NB - 1) repeat (CPB) @(negedge clk);
    end
    @(negedge clk);
    chk("done_early", tx_done, 0);
    chk("active_last_stop", tx_active, 1);
    @(negedge clk);
    chk("done_pulse", tx_done, 1);
    chk("active_in_cleanup", tx_active, 0);
    chk("serial_in_cleanup", tx_serial, 1);
    @(negedge clk);
    chk("done_single", tx_done, 0);
  endtask

  initial begin
    int f1;
    int f2;
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[4] = '{8'h01, 10'b1000000010, 1'b1};
    vecs[5] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[6] = '{8'h80, 10'b1100000000, 1'b1};

    rst_n   = 1'b0;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_serial", tx_serial, 1);
    chk("reset_active", tx_active, 0);
    chk("reset_done", tx_done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_serial", tx_serial, 1);
      chk("idle_active", tx_active, 0);
      chk("idle_done", tx_done, 0);
    end

    // Single frames from the vector table.
    for (int v = 0; v < 7; v++) begin
      sb.push_back(mk_line(vecs[v].line, vecs[v].par));
      fork
        frame_mon(f1);
        pulse(vecs[v].data);
      join
      $display("frame %0h sent, start at cycle %0d", vecs[v].data, f1);
      repeat (3) @(negedge clk);
    end

    // Requests mid-frame and during CLEANUP are ignored; byte changes have no effect.
    sb.push_back(mk_line(vecs[0].line, vecs[0].par));
    fork
      frame_mon(f1);
      begin
        pulse(8'hA5);
        repeat (10) @(negedge clk);
        pulse(8'h3C);
        repeat (5) @(negedge clk);
        tx_byte = 8'hFF;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (tx_done === 1'b1) break;
        end
        tx_dv = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
      end
    join
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("no_second_frame", tx_serial, 1);
    end
    $display("ignored-request frame done, start at cycle %0d", f1);

    // Held request: back-to-back frames with a two-cycle idle gap.
    sb.push_back(mk_line(vecs[1].line, vecs[1].par));
    sb.push_back(mk_line(vecs[2].line, vecs[2].par));
    tx_byte = 8'h00;
    tx_dv   = 1'b1;
    fork
      frame_mon(f1);
      begin
        repeat (8) @(negedge clk);
        tx_byte = 8'hFF;
      end
    join
    fork
      frame_mon(f2);
      begin
        repeat (8) @(negedge clk);
        tx_dv = 1'b0;
      end
    join
    chk("b2b_gap", f2 - f1, CPB * NB + 2);
    $display("back-to-back frames start at cycles %0d and %0d", f1, f2);
    repeat (60) @(negedge clk);
    chk("b2b_no_third", tx_serial, 1);

    // Asynchronous reset during data bit 4.
    pulse(8'hA5);
    repeat (21) @(negedge clk);
    chk("pre_reset_bit4", tx_serial, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_serial", tx_serial, 1);
    chk("async_rst_active", tx_active, 0);
    chk("async_rst_done", tx_done, 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_serial", tx_serial, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", tx_serial, 1);
    sb.push_back(mk_line(vecs[0].line, vecs[0].par));
    fork
      frame_mon(f1);
      pulse(8'hA5);
    join
    $display("post-reset frame A5, start at cycle %0d", f1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
